// File: rtl/mips_cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, the boot vector and the full-word
// byte-enable pattern used by the instruction and data bus masters.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR    = 32'hBFC00000;
  localparam logic [3:0]  WORD_BYTEENABLE = 4'b1111;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mips_cpu_ifetch_if.sv
// Avalon-MM read-only bus between the fetch unit (master) and the instruction
// memory (slave).
interface mips_cpu_ifetch_if;

  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    output avm_byteenable,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_byteenable,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/mips_cpu_byteswap.sv
// Combinational 32-bit byte reverser; ENABLE = 0 makes it a plain wire.
// Shared by the instruction fetch and the data-side memory unit.
module mips_cpu_byteswap #(
  parameter bit ENABLE = 1'b1
) (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      if (ENABLE) begin : g_swap
        assign dout[8*gi +: 8] = din[8*(3-gi) +: 8];
      end else begin : g_pass
        assign dout[8*gi +: 8] = din[8*gi +: 8];
      end
    end
  endgenerate

endmodule

// File: rtl/mips_cpu_ifetch.sv
// Instruction fetch: turns the PC into single outstanding Avalon word reads,
// holds the returned word for decode and pulses pc_advance on acceptance.
module mips_cpu_ifetch
  import mips_cpu_pkg::*;
#(
  parameter bit          SWAP_BYTES = 1'b0,
  parameter logic [31:0] HALT_ADDR  = 32'h00000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc,
  input  logic               fetch_en,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic               pc_advance,
  output logic               fetch_fault,
  output logic               halted,
  mips_cpu_ifetch_if.master  avm
);

  fetch_state_t state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic         fetch_fault_q, fetch_fault_d;
  logic         halted_q, halted_d;
  logic         read_q, read_d;
  logic [31:0]  address_q, address_d;
  logic [3:0]   byteenable_q, byteenable_d;
  logic [31:0]  rdata_ordered;

  mips_cpu_byteswap #(
    .ENABLE (SWAP_BYTES)
  ) u_byteswap (
    .din  (avm.avm_readdata),
    .dout (rdata_ordered)
  );

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fetch_fault_d = fetch_fault_q;
    halted_d      = halted_q;
    read_d        = read_q;
    address_d     = address_q;
    byteenable_d  = byteenable_q;

    case (state_q)
      IDLE: begin
        // Halt wins over misalignment; both are sticky until reset.
        if (fetch_en && !halted_q && !fetch_fault_q) begin
          if (pc == HALT_ADDR) begin
            halted_d = 1'b1;
          end else if (!word_aligned(pc)) begin
            fetch_fault_d = 1'b1;
          end else begin
            address_d    = pc;
            read_d       = 1'b1;
            byteenable_d = WORD_BYTEENABLE;
            state_d      = REQ;
          end
        end
      end
      REQ: begin
        if (!avm.avm_waitrequest) begin
          instr_d       = rdata_ordered;
          instr_valid_d = 1'b1;
          read_d        = 1'b0;
          byteenable_d  = 4'b0000;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      halted_q      <= 1'b0;
      read_q        <= 1'b0;
      address_q     <= 32'h0;
      byteenable_q  <= 4'b0000;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_fault_q <= fetch_fault_d;
      halted_q      <= halted_d;
      read_q        <= read_d;
      address_q     <= address_d;
      byteenable_q  <= byteenable_d;
    end
  end

  // Same-cycle pulse so the PC register steps on the edge that leaves HOLD.
  assign pc_advance = (state_q == HOLD) && instr_ready && !reset;

  assign instr              = instr_q;
  assign instr_valid        = instr_valid_q;
  assign fetch_fault        = fetch_fault_q;
  assign halted             = halted_q;
  assign avm.avm_read       = read_q;
  assign avm.avm_address    = address_q;
  assign avm.avm_byteenable = byteenable_q;

endmodule

// File: tb/tb_mips_cpu_ifetch.sv
// Randomized bench for mips_cpu_ifetch: a plain and a byte-swapping instance
// share stimulus and are checked cycle by cycle against transaction rules.
module tb_mips_cpu_ifetch;
  import mips_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        fetch_en = 1'b0;
  logic        instr_ready = 1'b0;
  logic        waitreq = 1'b0;
  logic [31:0] rdata = 32'h0;

  logic [31:0] instr0, instr1;
  logic        valid0, valid1, adv0, adv1, fault0, fault1, halt0, halt1;

  mips_cpu_ifetch_if avm0 ();
  mips_cpu_ifetch_if avm1 ();

  assign avm0.avm_waitrequest = waitreq;
  assign avm0.avm_readdata    = rdata;
  assign avm1.avm_waitrequest = waitreq;
  assign avm1.avm_readdata    = rdata;

  mips_cpu_ifetch #(.SWAP_BYTES(1'b0), .HALT_ADDR(32'h0)) dut0 (
    .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en), .instr_ready(instr_ready),
    .instr(instr0), .instr_valid(valid0), .pc_advance(adv0), .fetch_fault(fault0),
    .halted(halt0), .avm(avm0)
  );

  mips_cpu_ifetch #(.SWAP_BYTES(1'b1), .HALT_ADDR(32'h0)) dut1 (
    .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en), .instr_ready(instr_ready),
    .instr(instr1), .instr_valid(valid1), .pc_advance(adv1), .fetch_fault(fault1),
    .halted(halt1), .avm(avm1)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_instr = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected bus and handshake view of both instances in the current cycle.
  task automatic check_cycle(input string tag, input logic rd, input logic [31:0] addr,
                             input logic vld, input logic adv, input logic [31:0] ins);
    check({tag, ".read0"}, {31'h0, avm0.avm_read}, {31'h0, rd});
    check({tag, ".read1"}, {31'h0, avm1.avm_read}, {31'h0, rd});
    check({tag, ".be0"}, {28'h0, avm0.avm_byteenable}, rd ? {28'h0, WORD_BYTEENABLE} : 32'h0);
    check({tag, ".be1"}, {28'h0, avm1.avm_byteenable}, rd ? {28'h0, WORD_BYTEENABLE} : 32'h0);
    if (rd) begin
      check({tag, ".addr0"}, avm0.avm_address, addr);
      check({tag, ".addr1"}, avm1.avm_address, addr);
    end
    check({tag, ".valid0"}, {31'h0, valid0}, {31'h0, vld});
    check({tag, ".valid1"}, {31'h0, valid1}, {31'h0, vld});
    check({tag, ".adv0"}, {31'h0, adv0}, {31'h0, adv});
    check({tag, ".adv1"}, {31'h0, adv1}, {31'h0, adv});
    check({tag, ".instr0"}, instr0, ins);
    check({tag, ".instr1"}, instr1, swap32(ins));
  endtask

  task automatic check_flags(input string tag, input logic flt, input logic hlt);
    check({tag, ".fault0"}, {31'h0, fault0}, {31'h0, flt});
    check({tag, ".fault1"}, {31'h0, fault1}, {31'h0, flt});
    check({tag, ".halt0"}, {31'h0, halt0}, {31'h0, hlt});
    check({tag, ".halt1"}, {31'h0, halt1}, {31'h0, hlt});
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    fetch_en    = 1'($urandom % 2);
    instr_ready = 1'($urandom % 2);
    waitreq     = 1'($urandom % 2);
    next_cycle();
    check_cycle("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("reset.addr0", avm0.avm_address, 32'h0);
    check_flags("reset", 1'b0, 1'b0);
    reset      = 1'b0;
    fetch_en   = 1'b0;
    last_instr = 32'h0;
    $display("reset applied");
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) begin
      fetch_en    = 1'b0;
      instr_ready = 1'($urandom % 2);
      pc          = $urandom;
      #2;
      check_cycle("idle_off", 1'b0, 32'h0, 1'b0, 1'b0, last_instr);
      next_cycle();
    end
  endtask

  // One fetch: IDLE start, w wait states, completion, r cycles of backpressure.
  task automatic fetch_one(input logic [31:0] a, input logic [31:0] d, input int w, input int r);
    int cycles = 0;
    pc          = a;
    fetch_en    = 1'b1;
    instr_ready = 1'($urandom % 2);
    waitreq     = 1'($urandom % 2);
    rdata       = $urandom;
    #2;
    check_cycle("start", 1'b0, 32'h0, 1'b0, 1'b0, last_instr);
    next_cycle();
    cycles++;
    for (int k = 0; k <= w; k++) begin
      waitreq     = (k < w);
      rdata       = (k < w) ? $urandom : d;
      fetch_en    = 1'($urandom % 2);
      pc          = $urandom;
      instr_ready = 1'($urandom % 2);
      #2;
      check_cycle("req", 1'b1, a, 1'b0, 1'b0, last_instr);
      next_cycle();
      cycles++;
    end
    for (int k = 0; k <= r; k++) begin
      waitreq     = 1'($urandom % 2);
      rdata       = $urandom;
      fetch_en    = 1'($urandom % 2);
      instr_ready = (k == r);
      #2;
      check_cycle("hold", 1'b0, a, 1'b1, (k == r), d);
      next_cycle();
      cycles++;
    end
    last_instr = d;
    fetch_en   = 1'b0;
    $display("fetch addr=%08h data=%08h waits=%0d stalls=%0d cycles=%0d", a, d, w, r, cycles);
  endtask

  initial begin
    logic [31:0] a;
    do_reset();

    fetch_one(RESET_VECTOR, 32'h24020005, 0, 0);
    fetch_one(RESET_VECTOR + 32'd4, 32'h24020006, 4, 0);
    fetch_one(RESET_VECTOR + 32'd8, 32'h8C430010, 0, 3);
    fetch_one(RESET_VECTOR + 32'd12, 32'h11223344, 1, 1);
    check("swap.instr1", instr1, 32'h44332211);

    // Misaligned PC: sticky fault, no read ever starts.
    do_reset();
    pc = 32'hBFC00002; fetch_en = 1'b1;
    #2;
    check_cycle("misal", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    check_flags("misal", 1'b1, 1'b0);
    pc = 32'hBFC00004;
    for (int i = 0; i < 3; i++) begin
      check_cycle("misal_stuck", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check_flags("misal_stuck", 1'b1, 1'b0);
      next_cycle();
    end
    $display("misaligned fetch at bfc00002");

    // Halt address: sticky halted, no read.
    do_reset();
    pc = 32'h0; fetch_en = 1'b1;
    next_cycle();
    check_flags("halt", 1'b0, 1'b1);
    pc = RESET_VECTOR;
    for (int i = 0; i < 3; i++) begin
      check_cycle("halt_stuck", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check_flags("halt_stuck", 1'b0, 1'b1);
      next_cycle();
    end
    $display("halt at address 0");

    // Reset while a read is stalled abandons it.
    do_reset();
    pc = 32'hBFC00010; fetch_en = 1'b1; waitreq = 1'b1;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      check_cycle("abort_req", 1'b1, 32'hBFC00010, 1'b0, 1'b0, 32'h0);
      next_cycle();
    end
    reset = 1'b1; instr_ready = 1'b1;
    next_cycle();
    reset = 1'b0; waitreq = 1'b0; fetch_en = 1'b0; rdata = 32'hDEADBEEF;
    #2;
    check_cycle("abort", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    check_cycle("abort_idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    $display("reset during stalled read");
    fetch_one(32'hBFC00020, 32'h03E00008, 0, 0);

    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      a[1:0] = 2'b00;
      if (a == 32'h0) a = RESET_VECTOR;
      fetch_one(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      idle_n($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_cpu_ifetch.md
Name: mips_cpu_ifetch

Overview:
- Instruction-fetch reader that consumes the program counter and turns it into Avalon-style word reads on the instruction memory bus.
- Latches the returned word into an instruction holding register and offers it downstream with a valid/ready handshake.
- Drives a one-cycle pc_advance pulse that is the clk_enable of the PC register, so the PC steps only when the current instruction has been accepted.
- Flags misaligned fetch addresses and the halt address (PC == 0).

Parameters:
- SWAP_BYTES, 0, when 1 the byte order of readdata is reversed before latching (bus little-endian, core big-endian).
- HALT_ADDR, 32'h00000000, fetch address that stops fetching and raises halted.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  current fetch address from the PC register.
- fetch_en  in  1  core-level enable; when 0, no new read is started.
- instr_ready  in  1  downstream decode accepts instr this cycle.
- instr  out  32  latched instruction word.
- instr_valid  out  1  instr holds an unconsumed word.
- pc_advance  out  1  one-cycle pulse; PC register clk_enable.
- fetch_fault  out  1  sticky; set when pc[1:0] != 0 at read start.
- halted  out  1  sticky; set when pc == HALT_ADDR at read start.
- avm_address  out  32  word-aligned bus address.
- avm_read  out  1  read request.
- avm_byteenable  out  4  always 4'b1111 while avm_read = 1, else 0.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data, valid in the cycle avm_read = 1 and avm_waitrequest = 0.

Behaviour:
- Reset values: state = IDLE; instr = 0; instr_valid = 0; pc_advance = 0; fetch_fault = 0; halted = 0; avm_read = 0; avm_address = 0; avm_byteenable = 0.
- Reset asserted mid-read drops avm_read in the next cycle with no completion. The slave is expected to tolerate an abandoned read.
- IDLE:
  - If fetch_en = 1, halted = 0 and fetch_fault = 0:
    - pc == HALT_ADDR -> set halted, stay IDLE.
    - else pc[1:0] != 0 -> set fetch_fault, stay IDLE.
    - else -> capture avm_address = pc, assert avm_read, go to REQ.
  - halted and fetch_fault are evaluated at read start only, and halted has priority over fetch_fault.
- REQ:
  - avm_read, avm_address and avm_byteenable are held stable while avm_waitrequest = 1.
  - Completion cycle (avm_waitrequest = 0):
    - latch avm_readdata (byte-swapped if SWAP_BYTES) into instr;
    - set instr_valid = 1;
    - deassert avm_read next cycle;
    - go to HOLD.
  - fetch_en falling during REQ does not cancel the read.
- HOLD:
  - instr_valid = 1.
  - If instr_ready = 1 -> pulse pc_advance for exactly that cycle, clear instr_valid next cycle, go to IDLE.
  - instr is unchanged until the next completion.
- Latency:
  - Minimum 3 cycles per instruction: IDLE -> REQ (zero-wait completion) -> HOLD (accepted) -> IDLE.
  - Each waitrequest cycle adds one cycle.
- pc is sampled only in IDLE. The PC register updates on the edge that ends the pc_advance cycle, so the next IDLE sees the new pc.
- Branch delay slots are handled entirely by the PC register. This block never flushes; every accepted word is a real instruction.
- Never more than one outstanding read; avm_read is never asserted in HOLD or IDLE.
- Simultaneous instr_ready in the completion cycle of REQ is ignored; acceptance happens only in HOLD.

Decomposition:
- Shared package mips_cpu_pkg holds:
  - the fetch state enum typedef (IDLE, REQ, HOLD);
  - localparams RESET_VECTOR = 32'hBFC00000 and WORD_BYTEENABLE = 4'b1111.
- One sub-module is natural: mips_cpu_byteswap, a combinational 32-bit byte reverser that is enabled by SWAP_BYTES and reused by the data-side memory unit.

Test Plan:
1. Reset, pc = 32'hBFC00000, fetch_en = 1, waitrequest = 0, readdata = 32'h24020005, instr_ready = 1 -> avm_read high 1 cycle with address BFC00000; instr = 24020005, instr_valid = 1; pc_advance pulses 1 cycle; 3 cycles total.
2. Same as test 1 with waitrequest held high 4 cycles -> address and read stable for 5 cycles; single completion; latency 7 cycles.
3. instr_ready = 0 for 3 cycles after completion -> instr_valid held; no pc_advance and no new read until ready; then one pulse.
4. pc = 32'hBFC00002 -> no avm_read; fetch_fault = 1 and stays set. pc = 0 -> halted = 1, no read.
5. SWAP_BYTES = 1, readdata = 32'h11223344 -> instr = 32'h44332211.
6. reset asserted while in REQ with waitrequest high -> next cycle avm_read = 0, instr_valid = 0, state IDLE, no pc_advance.
